uart_port_arbiter: RTL and testbench

- Shares the single AXI4-lite UART (RX_FIFO 0x0, TX_FIFO 0x4, STAT_REG 0x8) between two byte-level requesters: port 0 is the loader/dump path, port 1 is core I/O.
- Each request is one byte read or one byte write. The block polls STAT_REG, performs the FIFO access and returns a completion pulse.
- Requesters never drive the AXI bus directly.

---
 rtl/uart_port_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_port_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_port_arbiter.sv
// Two-port byte arbiter in front of a single AXI4-lite UART: polls STAT_REG, then
// performs one RX_FIFO read or TX_FIFO write per granted request and pulses completion.
module uart_port_arbiter #(
    parameter int POLL_LIMIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [15:0] req_wdata,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_done,
    output logic        rsp_err,
    output logic [7:0]  rsp_rdata,
    output logic [3:0]  uart_axi_araddr,
    output logic        uart_axi_arvalid,
    input  logic        uart_axi_arready,
    input  logic [31:0] uart_axi_rdata,
    input  logic [1:0]  uart_axi_rresp,
    input  logic        uart_axi_rvalid,
    output logic        uart_axi_rready,
    output logic [3:0]  uart_axi_awaddr,
    output logic        uart_axi_awvalid,
    input  logic        uart_axi_awready,
    output logic [31:0] uart_axi_wdata,
    output logic [3:0]  uart_axi_wstrb,
    output logic        uart_axi_wvalid,
    input  logic        uart_axi_wready,
    input  logic [1:0]  uart_axi_bresp,
    input  logic        uart_axi_bvalid,
    output logic        uart_axi_bready
);

    localparam int CW = (POLL_LIMIT == 0) ? 1 : $clog2(POLL_LIMIT + 1);

    localparam logic [3:0] ADDR_RX   = 4'h0;
    localparam logic [3:0] ADDR_TX   = 4'h4;
    localparam logic [3:0] ADDR_STAT = 4'h8;

    typedef enum logic [2:0] {
        IDLE, STAT_AR, STAT_R, DATA_AR, DATA_R, WR_AW_W, WR_B, DONE
    } state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            grant_q, grant_d;
    logic            write_q, write_d;
    logic [7:0]      wbyte_q, wbyte_d;
    logic [CW-1:0]   poll_cnt_q, poll_cnt_d;
    logic            err_q, err_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            arvalid_q, arvalid_d;
    logic [3:0]      araddr_q, araddr_d;
    logic            rready_q, rready_d;
    logic            awvalid_q, awvalid_d;
    logic [3:0]      awaddr_q, awaddr_d;
    logic            wvalid_q, wvalid_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic            bready_q, bready_d;

    logic            grant_sel;
    logic [1:0]      req_ready_c;
    logic [CW-1:0]   poll_cnt_sat;
    logic            aw_done, w_done;

    // Only status bits 0 (RX data available) and 3 (TX full) and the RX byte matter.
    logic unused_rdata_bits;
    assign unused_rdata_bits = &{1'b0, uart_axi_rdata[31:8]};

    assign grant_sel    = (&req_valid) ? ~last_grant_q : req_valid[1];
    assign poll_cnt_sat = (poll_cnt_q == {CW{1'b1}}) ? poll_cnt_q : poll_cnt_q + CW'(1);
    assign aw_done      = !awvalid_q || uart_axi_awready;
    assign w_done       = !wvalid_q  || uart_axi_wready;

    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        write_d      = write_q;
        wbyte_d      = wbyte_q;
        poll_cnt_d   = poll_cnt_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        awaddr_d     = awaddr_q;
        wvalid_d     = wvalid_q;
        wstrb_d      = wstrb_q;
        bready_d     = bready_q;
        req_ready_c  = 2'b00;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready_c  = grant_sel ? 2'b10 : 2'b01;
                    grant_d      = grant_sel;
                    last_grant_d = grant_sel;
                    write_d      = req_write[grant_sel];
                    wbyte_d      = grant_sel ? req_wdata[15:8] : req_wdata[7:0];
                    poll_cnt_d   = '0;
                    err_d        = 1'b0;
                    araddr_d     = ADDR_STAT;
                    arvalid_d    = 1'b1;
                    state_d      = STAT_AR;
                end
            end
            STAT_AR, DATA_AR: begin
                if (uart_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = (state_q == STAT_AR) ? STAT_R : DATA_R;
                end
            end
            STAT_R: begin
                if (uart_axi_rvalid) begin
                    rready_d = 1'b0;
                    if (uart_axi_rresp != 2'b00) begin
                        err_d   = 1'b1;
                        rdata_d = 8'h00;
                        state_d = DONE;
                    end else if (!write_q && uart_axi_rdata[0]) begin
                        araddr_d  = ADDR_RX;
                        arvalid_d = 1'b1;
                        state_d   = DATA_AR;
                    end else if (write_q && !uart_axi_rdata[3]) begin
                        awaddr_d  = ADDR_TX;
                        wstrb_d   = 4'b0001;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_AW_W;
                    end else begin
                        poll_cnt_d = poll_cnt_sat;
                        if (POLL_LIMIT != 0 && poll_cnt_sat == CW'(POLL_LIMIT)) begin
                            err_d   = 1'b1;
                            rdata_d = 8'h00;
                            state_d = DONE;
                        end else begin
                            araddr_d  = ADDR_STAT;
                            arvalid_d = 1'b1;
                            state_d   = STAT_AR;
                        end
                    end
                end
            end
            DATA_R: begin
                if (uart_axi_rvalid) begin
                    rready_d = 1'b0;
                    rdata_d  = uart_axi_rdata[7:0];
                    err_d    = (uart_axi_rresp != 2'b00);
                    state_d  = DONE;
                end
            end
            WR_AW_W: begin
                // AW and W complete independently; move on once both have been taken.
                if (awvalid_q && uart_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && uart_axi_wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = WR_B;
                end
            end
            WR_B: begin
                if (uart_axi_bvalid) begin
                    bready_d = 1'b0;
                    err_d    = (uart_axi_bresp != 2'b00);
                    rdata_d  = 8'h00;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            write_q      <= 1'b0;
            wbyte_q      <= 8'h00;
            poll_cnt_q   <= '0;
            err_q        <= 1'b0;
            rdata_q      <= 8'h00;
            arvalid_q    <= 1'b0;
            araddr_q     <= ADDR_STAT;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            awaddr_q     <= ADDR_STAT;
            wvalid_q     <= 1'b0;
            wstrb_q      <= 4'b0000;
            bready_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            write_q      <= write_d;
            wbyte_q      <= wbyte_d;
            poll_cnt_q   <= poll_cnt_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            awaddr_q     <= awaddr_d;
            wvalid_q     <= wvalid_d;
            wstrb_q      <= wstrb_d;
            bready_q     <= bready_d;
        end
    end

    // The accept pulse is masked during reset, otherwise a grant could be signalled and then lost.
    assign req_ready        = rst ? 2'b00 : req_ready_c;
    assign rsp_done         = (state_q == DONE) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_err          = (state_q == DONE) && err_q;
    assign rsp_rdata        = rdata_q;
    assign uart_axi_araddr  = araddr_q;
    assign uart_axi_arvalid = arvalid_q;
    assign uart_axi_rready  = rready_q;
    assign uart_axi_awaddr  = awaddr_q;
    assign uart_axi_awvalid = awvalid_q;
    assign uart_axi_wdata   = {24'h000000, wbyte_q};
    assign uart_axi_wstrb   = wstrb_q;
    assign uart_axi_wvalid  = wvalid_q;
    assign uart_axi_bready  = bready_q;

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Directed bench for uart_port_arbiter: a behavioural AXI4-lite UART slave drives the
// main instance, a second instance with POLL_LIMIT=3 exercises the poll abort.
module tb_uart_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        rv0 = 1'b0, rv1 = 1'b0, rw0 = 1'b0, rw1 = 1'b0;
    logic [7:0]  wd0 = 8'h00, wd1 = 8'h00;
    logic [1:0]  req_valid, req_write;
    logic [15:0] req_wdata;
    assign req_valid = {rv1, rv0};
    assign req_write = {rw1, rw0};
    assign req_wdata = {wd1, wd0};

    logic [1:0]  req_ready, rsp_done;
    logic        rsp_err;
    logic [7:0]  rsp_rdata;
    logic [3:0]  araddr, awaddr;
    logic        arvalid, rready, awvalid, wvalid, bready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [1:0]  rresp = 2'b00, bresp = 2'b00;

    uart_port_arbiter #(.POLL_LIMIT(0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_done(rsp_done), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .uart_axi_araddr(araddr), .uart_axi_arvalid(arvalid), .uart_axi_arready(arready),
        .uart_axi_rdata(rdata), .uart_axi_rresp(rresp), .uart_axi_rvalid(rvalid),
        .uart_axi_rready(rready),
        .uart_axi_awaddr(awaddr), .uart_axi_awvalid(awvalid), .uart_axi_awready(awready),
        .uart_axi_wdata(wdata), .uart_axi_wstrb(wstrb), .uart_axi_wvalid(wvalid),
        .uart_axi_wready(wready),
        .uart_axi_bresp(bresp), .uart_axi_bvalid(bvalid), .uart_axi_bready(bready)
    );

    // Poll-limited instance: STAT always reads 0x0, so reads never find RX data.
    logic [1:0]  p_req_valid = 2'b00;
    logic [1:0]  p_req_ready, p_rsp_done;
    logic        p_rsp_err;
    logic [7:0]  p_rsp_rdata;
    logic [3:0]  p_araddr, p_awaddr;
    logic        p_arvalid, p_rready, p_awvalid, p_wvalid, p_bready;
    logic [31:0] p_wdata;
    logic [3:0]  p_wstrb;
    logic        p_arready = 1'b1, p_rvalid = 1'b0;
    logic [31:0] p_rdata = 32'h0;

    uart_port_arbiter #(.POLL_LIMIT(3)) dut_p (
        .clk(clk), .rst(rst),
        .req_valid(p_req_valid), .req_write(2'b00), .req_wdata(16'h0000),
        .req_ready(p_req_ready), .rsp_done(p_rsp_done), .rsp_err(p_rsp_err),
        .rsp_rdata(p_rsp_rdata),
        .uart_axi_araddr(p_araddr), .uart_axi_arvalid(p_arvalid), .uart_axi_arready(p_arready),
        .uart_axi_rdata(p_rdata), .uart_axi_rresp(2'b00), .uart_axi_rvalid(p_rvalid),
        .uart_axi_rready(p_rready),
        .uart_axi_awaddr(p_awaddr), .uart_axi_awvalid(p_awvalid), .uart_axi_awready(1'b0),
        .uart_axi_wdata(p_wdata), .uart_axi_wstrb(p_wstrb), .uart_axi_wvalid(p_wvalid),
        .uart_axi_wready(1'b0),
        .uart_axi_bresp(2'b00), .uart_axi_bvalid(1'b0), .uart_axi_bready(p_bready)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave configuration and observation state.
    logic [31:0] stat_q[$];
    logic [31:0] stat_default = 32'h1;
    logic [7:0]  rx_byte = 8'h00;
    logic [1:0]  data_rresp = 2'b00;
    int          aw_delay = 0, w_delay = 0;
    int          cyc = 0;
    logic        rd_pending = 1'b0, aw_got = 1'b0, w_got = 1'b0, b_pending = 1'b0;
    logic [3:0]  rd_addr = 4'h8;
    int          aw_wait = 0, w_wait = 0;
    logic        aw_hs_last = 1'b0, aw_wait_last = 1'b0, w_hs_last = 1'b0, w_wait_last = 1'b0;
    int          stat_reads, rx_reads, writes, b_hs, overlap_err, drop_err, aw_cyc, w_cyc;
    logic [3:0]  ar_log[$];
    logic [31:0] wdata_log[$];
    logic [3:0]  aw_addr_seen, wstrb_seen;
    int          rr_cnt0, rr_cnt1;
    int          grant_log[$], grant_cyc[$];
    int          done_port[$], done_cyc[$];
    logic        done_err[$];
    logic [7:0]  done_rdata[$];
    int          p_stat_reads = 0, p_rx_reads = 0, p_done_cnt = 0;
    logic        p_done_err = 1'b0;
    logic [1:0]  p_done_vec = 2'b00;
    logic        p_rd_pending = 1'b0;

    task automatic clear_logs();
        stat_reads = 0; rx_reads = 0; writes = 0; b_hs = 0;
        overlap_err = 0; drop_err = 0; aw_cyc = 0; w_cyc = 0;
        rr_cnt0 = 0; rr_cnt1 = 0;
        ar_log.delete(); wdata_log.delete(); stat_q.delete();
        grant_log.delete(); grant_cyc.delete();
        done_port.delete(); done_cyc.delete(); done_err.delete(); done_rdata.delete();
        aw_addr_seen = 4'h0; wstrb_seen = 4'h0;
    endtask

    // Slave inputs change on the falling edge; handshakes complete on the following rising edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
            rd_pending = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_pending = 1'b0;
            aw_wait = 0; w_wait = 0;
            aw_hs_last = 1'b0; aw_wait_last = 1'b0; w_hs_last = 1'b0; w_wait_last = 1'b0;
        end else begin
            arready = 1'b1;
            rvalid  = rd_pending;
            if (rd_addr == 4'h8) begin
                rdata = (stat_q.size() > 0) ? stat_q[0] : stat_default;
                rresp = 2'b00;
            end else begin
                rdata = {24'h0, rx_byte};
                rresp = data_rresp;
            end
            awready = awvalid && (aw_wait >= aw_delay);
            wready  = wvalid && (w_wait >= w_delay);
            bvalid  = b_pending;
            bresp   = 2'b00;

            if (aw_hs_last && awvalid) drop_err++;
            if (aw_wait_last && !awvalid) drop_err++;
            if (w_hs_last && wvalid) drop_err++;
            if (w_wait_last && !wvalid) drop_err++;

            if (rvalid && rready) begin
                rd_pending = 1'b0;
                if (rd_addr == 4'h8 && stat_q.size() > 0) void'(stat_q.pop_front());
            end
            if (arvalid && arready) begin
                if (rd_pending || awvalid || wvalid || aw_got || w_got || b_pending) overlap_err++;
                ar_log.push_back(araddr);
                if (araddr == 4'h8) stat_reads++;
                else if (araddr == 4'h0) rx_reads++;
                rd_pending = 1'b1;
                rd_addr    = araddr;
            end
            aw_hs_last   = awvalid && awready;
            aw_wait_last = awvalid && !awready;
            if (aw_hs_last) begin
                if (rd_pending || arvalid) overlap_err++;
                aw_got = 1'b1; aw_wait = 0; writes++;
                aw_addr_seen = awaddr; aw_cyc = cyc;
            end else if (awvalid) aw_wait++;
            w_hs_last   = wvalid && wready;
            w_wait_last = wvalid && !wready;
            if (w_hs_last) begin
                w_got = 1'b1; w_wait = 0;
                wdata_log.push_back(wdata); wstrb_seen = wstrb; w_cyc = cyc;
            end else if (wvalid) w_wait++;
            if (bvalid && bready) begin
                b_pending = 1'b0; b_hs++;
            end
            if (aw_got && w_got) begin
                b_pending = 1'b1; aw_got = 1'b0; w_got = 1'b0;
            end
        end

        #3;
        if (req_ready != 2'b00) begin
            grant_log.push_back(int'(req_ready[1]));
            grant_cyc.push_back(cyc);
            if (req_ready[0]) rr_cnt0++;
            if (req_ready[1]) rr_cnt1++;
        end
        if (rsp_done != 2'b00) begin
            done_port.push_back(int'(rsp_done[1]));
            done_err.push_back(rsp_err);
            done_rdata.push_back(rsp_rdata);
            done_cyc.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            p_rd_pending = 1'b0; p_rvalid = 1'b0;
        end else begin
            p_rvalid = p_rd_pending;
            p_rdata  = 32'h0;
            if (p_rvalid && p_rready) p_rd_pending = 1'b0;
            if (p_arvalid && p_arready) begin
                p_rd_pending = 1'b1;
                if (p_araddr == 4'h8) p_stat_reads++;
                else p_rx_reads++;
            end
        end
        #3;
        if (p_rsp_done != 2'b00) begin
            p_done_cnt++; p_done_err = p_rsp_err; p_done_vec = p_rsp_done;
        end
    end

    task automatic do_req(input int p, input logic w, input logic [7:0] d, input bit keep);
        bit ok;
        ok = 1'b0;
        @(negedge clk); #1;
        if (p == 0) begin rv0 = 1'b1; rw0 = w; wd0 = d; end
        else        begin rv1 = 1'b1; rw1 = w; wd1 = d; end
        for (int n = 0; n < 500 && !ok; n++) begin
            #1;
            if (req_ready[p]) ok = 1'b1;
            else begin @(negedge clk); #1; end
        end
        check($sformatf("req_accept_p%0d", p), 32'(ok), 32'd1);
        if (ok) @(posedge clk);
        if (!keep) begin
            #1;
            if (p == 0) rv0 = 1'b0; else rv1 = 1'b0;
        end
    endtask

    task automatic wait_done_count(input int n);
        for (int i = 0; i < 3000 && done_port.size() < n; i++) @(negedge clk);
        #4;
        check("done_count", 32'(done_port.size()), 32'(n));
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req_ready"}, 32'(req_ready), 32'h0);
        check({pfx, "_rsp_done"},  32'(rsp_done),  32'h0);
        check({pfx, "_rsp_err"},   32'(rsp_err),   32'h0);
        check({pfx, "_rsp_rdata"}, 32'(rsp_rdata), 32'h0);
        check({pfx, "_arvalid"},   32'(arvalid),   32'h0);
        check({pfx, "_rready"},    32'(rready),    32'h0);
        check({pfx, "_awvalid"},   32'(awvalid),   32'h0);
        check({pfx, "_wvalid"},    32'(wvalid),    32'h0);
        check({pfx, "_bready"},    32'(bready),    32'h0);
        check({pfx, "_araddr"},    32'(araddr),    32'h8);
        check({pfx, "_awaddr"},    32'(awaddr),    32'h8);
        check({pfx, "_wstrb"},     32'(wstrb),     32'h0);
        check({pfx, "_wdata"},     wdata,          32'h0);
    endtask

    logic [7:0] p1_bytes[4] = '{8'hA1, 8'hB2, 8'hC4, 8'hD8};

    initial begin
        bit ok;
        clear_logs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        check_reset_outputs("reset");
        check("reset_p_ready", 32'(p_req_ready), 32'h0);
        #1 rst = 1'b0;

        // Port 0 read: one status poll, one RX read, done five cycles after accept.
        clear_logs();
        stat_default = 32'h1; rx_byte = 8'h5A;
        do_req(0, 1'b0, 8'h00, 1'b0);
        wait_done_count(1);
        check("rd_ready_pulses", 32'(rr_cnt0), 32'd1);
        check("rd_ar_count",     32'(ar_log.size()), 32'd2);
        check("rd_ar0_addr",     32'(ar_log[0]), 32'h8);
        check("rd_ar1_addr",     32'(ar_log[1]), 32'h0);
        check("rd_done_port",    32'(done_port[0]), 32'd0);
        check("rd_rdata",        32'(done_rdata[0]), 32'h5A);
        check("rd_err",          32'(done_err[0]), 32'd0);
        check("rd_latency",      32'(done_cyc[0] - grant_cyc[0]), 32'd5);
        check("rd_no_writes",    32'(writes), 32'd0);

        // Port 1 write of 0xC3 after three TX-full polls.
        clear_logs();
        stat_q = '{32'h8, 32'h8, 32'h8, 32'h0};
        do_req(1, 1'b1, 8'hC3, 1'b0);
        wait_done_count(1);
        check("wr_stat_reads", 32'(stat_reads), 32'd4);
        check("wr_rx_reads",   32'(rx_reads), 32'd0);
        check("wr_writes",     32'(writes), 32'd1);
        check("wr_awaddr",     32'(aw_addr_seen), 32'h4);
        check("wr_wdata",      wdata_log[0], 32'h000000C3);
        check("wr_wstrb",      32'(wstrb_seen), 32'h1);
        check("wr_b_hs",       32'(b_hs), 32'd1);
        check("wr_done_port",  32'(done_port[0]), 32'd1);
        check("wr_err",        32'(done_err[0]), 32'd0);
        check("wr_rdata_zero", 32'(done_rdata[0]), 32'h0);

        // Both ports contend continuously: four reads on port 0, four writes on port 1.
        clear_logs();
        stat_default = 32'h1; rx_byte = 8'h3C;
        fork
            begin
                for (int i = 0; i < 4; i++) do_req(0, 1'b0, 8'h00, i < 3);
            end
            begin
                for (int i = 0; i < 4; i++) do_req(1, 1'b1, p1_bytes[i], i < 3);
            end
        join
        wait_done_count(8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rr_grant_%0d", i), 32'(grant_log[i]), 32'(i % 2));
            check($sformatf("rr_done_%0d", i),  32'(done_port[i]), 32'(i % 2));
            check($sformatf("rr_rdata_%0d", i), 32'(done_rdata[i]), (i % 2 == 0) ? 32'h3C : 32'h0);
        end
        for (int j = 0; j < 4; j++)
            check($sformatf("rr_wdata_%0d", j), wdata_log[j], {24'h0, p1_bytes[j]});
        check("rr_overlap", 32'(overlap_err), 32'd0);
        check("rr_rx_reads", 32'(rx_reads), 32'd4);
        check("rr_writes", 32'(writes), 32'd4);

        // AW accepted two cycles before W, then W two cycles before AW.
        clear_logs();
        aw_delay = 0; w_delay = 2;
        do_req(0, 1'b1, 8'h11, 1'b0);
        wait_done_count(1);
        check("aww_gap",  32'(w_cyc - aw_cyc), 32'd2);
        check("aww_drop", 32'(drop_err), 32'd0);
        check("aww_b_hs", 32'(b_hs), 32'd1);
        check("aww_err",  32'(done_err[0]), 32'd0);
        check("aww_data", wdata_log[0], 32'h11);
        clear_logs();
        aw_delay = 2; w_delay = 0;
        do_req(0, 1'b1, 8'h22, 1'b0);
        wait_done_count(1);
        check("waw_gap",  32'(aw_cyc - w_cyc), 32'd2);
        check("waw_drop", 32'(drop_err), 32'd0);
        check("waw_b_hs", 32'(b_hs), 32'd1);
        check("waw_err",  32'(done_err[0]), 32'd0);
        aw_delay = 0; w_delay = 0;

        // Poll limit of 3 on a read that never sees RX data.
        ok = 1'b0;
        @(negedge clk); #1;
        p_req_valid = 2'b01;
        for (int n = 0; n < 100 && !ok; n++) begin
            #1;
            if (p_req_ready[0]) ok = 1'b1;
            else begin @(negedge clk); #1; end
        end
        check("pl_accept", 32'(ok), 32'd1);
        if (ok) @(posedge clk);
        #1 p_req_valid = 2'b00;
        for (int i = 0; i < 200 && p_done_cnt == 0; i++) @(negedge clk);
        #4;
        check("pl_done_cnt",   32'(p_done_cnt), 32'd1);
        check("pl_done_vec",   32'(p_done_vec), 32'h1);
        check("pl_err",        32'(p_done_err), 32'd1);
        check("pl_stat_reads", 32'(p_stat_reads), 32'd3);
        check("pl_rx_reads",   32'(p_rx_reads), 32'd0);

        // Error response on the RX data read.
        clear_logs();
        data_rresp = 2'b10; rx_byte = 8'h77;
        do_req(1, 1'b0, 8'h00, 1'b0);
        wait_done_count(1);
        check("rresp_done_port", 32'(done_port[0]), 32'd1);
        check("rresp_err",       32'(done_err[0]), 32'd1);
        check("rresp_rx_reads",  32'(rx_reads), 32'd1);
        data_rresp = 2'b00;

        // Reset while stalled in the AW/W phase.
        clear_logs();
        aw_delay = 10; w_delay = 10;
        do_req(0, 1'b1, 8'h99, 1'b0);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk); #1;
            if (awvalid && wvalid) ok = 1'b1;
        end
        check("rst_in_wr", 32'(ok), 32'd1);
        rst = 1'b1;
        @(negedge clk); #3;
        check_reset_outputs("midrst");
        rst = 1'b0;
        aw_delay = 0; w_delay = 0;
        clear_logs();
        stat_default = 32'h1; rx_byte = 8'hE7;
        do_req(0, 1'b0, 8'h00, 1'b0);
        wait_done_count(1);
        check("post_rst_port",    32'(done_port[0]), 32'd0);
        check("post_rst_rdata",   32'(done_rdata[0]), 32'hE7);
        check("post_rst_err",     32'(done_err[0]), 32'd0);
        check("post_rst_latency", 32'(done_cyc[0] - grant_cyc[0]), 32'd5);
        check("post_rst_writes",  32'(writes), 32'd0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule
